// File: rtl/fsmc_bridge_pkg.sv
// Shared FSM encoding and default widths for the FSMC slave bridge.
package fsmc_bridge_pkg;

    localparam int unsigned DEF_FSMC_AW = 16;
    localparam int unsigned DEF_MEM_AW  = 22;

    typedef enum logic [2:0] {
        IDLE,
        WR_CAP,
        WR_REQ,
        RD_REQ,
        RD_WAIT,
        RD_HOLD
    } bridge_state_t;

endpackage

// File: rtl/fsmc_sync.sv
// Multi-stage bus synchroniser; every bit sees the same depth so the
// synchronised FSMC strobes, address and data stay mutually aligned.
module fsmc_sync #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge clk) begin
        stage[0] <= d;
        for (int unsigned i = 1; i < STAGES; i++) begin
            stage[i] <= stage[i-1];
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/fsmc_slave_bridge.sv
// STM32 FSMC asynchronous slave to single-word synchronous memory requests.
// Optional macro FSMC_NWAIT_EN adds the active-low fsmc_nwait stall output.
module fsmc_slave_bridge
    import fsmc_bridge_pkg::*;
#(
    parameter int unsigned FSMC_AW     = DEF_FSMC_AW,
    parameter int unsigned MEM_AW      = DEF_MEM_AW,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FSMC_AW-1:0] fsmc_a,
    input  logic [15:0]        fsmc_d_in,
    output logic [15:0]        fsmc_d_out,
    output logic               fsmc_d_oe,
    input  logic               fsmc_ne1,
    input  logic               fsmc_nwe,
    input  logic               fsmc_noe,
    input  logic               fsmc_nbl1,
    input  logic               fsmc_nbl0,
    output logic               mem_req,
    output logic               mem_we,
    output logic [MEM_AW-1:0]  mem_addr,
    output logic [15:0]        mem_wdata,
    output logic [1:0]         mem_wmask,
    input  logic               mem_ack,
    input  logic               mem_rvalid,
    input  logic [15:0]        mem_rdata,
    output logic               overrun,
`ifdef FSMC_NWAIT_EN
    output logic               fsmc_nwait,
`endif
    output logic               busy
);

    localparam int unsigned SW = 5 + FSMC_AW + 16;

    logic [SW-1:0]      sync_q;
    logic               ne1s, nwes, noes, nbl1s, nbl0s;
    logic [FSMC_AW-1:0] a_s;
    logic [15:0]        d_s;
    logic               ne1s_d;
    logic               armed;
    logic               ne1_fall;
    bridge_state_t      state;

    fsmc_sync #(
        .WIDTH (SW),
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .d  ({fsmc_ne1, fsmc_nwe, fsmc_noe, fsmc_nbl1, fsmc_nbl0, fsmc_a, fsmc_d_in}),
        .q  (sync_q)
    );

    assign {ne1s, nwes, noes, nbl1s, nbl0s, a_s, d_s} = sync_q;
    assign ne1_fall = ne1s_d & ~ne1s;

    // A colliding cycle also disarms, so it cannot start once the FSM is back in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            armed      <= 1'b0;
            ne1s_d     <= 1'b1;
            overrun    <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wmask  <= '0;
            fsmc_d_out <= '0;
        end else begin
            ne1s_d <= ne1s;
            if (ne1_fall && state != IDLE && state != RD_HOLD) begin
                overrun <= 1'b1;
                armed   <= 1'b0;
            end else if (ne1s) begin
                armed <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (armed && !ne1s && !nwes) begin
                        state     <= WR_CAP;
                        mem_addr  <= MEM_AW'(a_s);
                        mem_wdata <= d_s;
                        mem_wmask <= {~nbl1s, ~nbl0s};
                    end else if (armed && !ne1s && !noes) begin
                        state     <= RD_REQ;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= MEM_AW'(a_s);
                        mem_wmask <= 2'b11;
                    end
                end
                WR_CAP: begin
                    if (ne1s || nwes) begin
                        state   <= WR_REQ;
                        mem_req <= 1'b1;
                        mem_we  <= 1'b1;
                    end else begin
                        mem_addr  <= MEM_AW'(a_s);
                        mem_wdata <= d_s;
                        mem_wmask <= {~nbl1s, ~nbl0s};
                    end
                end
                WR_REQ: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                    end
                end
                RD_REQ: begin
                    if (mem_ack) begin
                        state   <= RD_WAIT;
                        mem_req <= 1'b0;
                    end
                end
                RD_WAIT: begin
                    if (mem_rvalid) begin
                        fsmc_d_out <= mem_rdata;
                        state      <= (!ne1s && !noes) ? RD_HOLD : IDLE;
                    end
                end
                RD_HOLD: begin
                    if (ne1s || noes) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Raw pins so drive releases the instant the host lifts NOE or NE1.
    assign fsmc_d_oe = (state == RD_HOLD) & ~fsmc_ne1 & ~fsmc_noe;
    assign busy      = (state != IDLE);

`ifdef FSMC_NWAIT_EN
    assign fsmc_nwait = ~(((state == WR_CAP) || (state == WR_REQ) ||
                           (state == RD_REQ) || (state == RD_WAIT)) && !ne1s);
`endif

endmodule

// File: doc/fsmc_slave_bridge.md
Name: fsmc_slave_bridge

Overview:
- Converts asynchronous STM32 FSMC bus cycles (NE1/NWE/NOE/NBL, 16-bit A/D) into single-word synchronous requests to the SDRAM controller, in the `clk` domain.
- Sits between the top-level FSMC pins and the SDRAM controller's request port.
- Returns read data to the FSMC data bus.
- The top level owns the `fsmc_d` tristate; this block supplies the data-out value and the output-enable.

Parameters:
- FSMC_AW, 16, FSMC address width (word address).
- MEM_AW, 22, SDRAM controller word-address width; requires MEM_AW >= FSMC_AW.
- SYNC_STAGES, 2, synchroniser depth for strobes, address and data-in; legal values 2..3.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- fsmc_a  in  FSMC_AW  FSMC address.
- fsmc_d_in  in  16  FSMC data from pins.
- fsmc_d_out  out  16  read data to pins.
- fsmc_d_oe  out  1  pin output-enable, high = drive.
- fsmc_ne1, fsmc_nwe, fsmc_noe  in  1  active-low chip select, write strobe, output enable.
- fsmc_nbl1, fsmc_nbl0  in  1  active-low byte lanes.
- mem_req  out  1  request valid.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  MEM_AW  word address, fsmc_a zero-extended.
- mem_wdata  out  16  write data.
- mem_wmask  out  2  byte mask, 1 = write the lane; {~nbl1, ~nbl0}.
- mem_ack  in  1  one-cycle acceptance.
- mem_rvalid  in  1  one-cycle read-data strobe.
- mem_rdata  in  16  read data.
- overrun  out  1  sticky error flag.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Synchronisers: all FSMC inputs pass through SYNC_STAGES flops, so address, data and strobes stay mutually aligned.
  - ne1s/nwes/noes denote the synchronised strobes.
  - Capture registers load every cycle while (ne1s=0 & nwes=0); the last value loaded is the write payload.
- Reset: all outputs 0, FSM = IDLE, armed = 0.
  - armed sets on the first cycle with ne1s=1.
  - Bus cycles already in progress at reset release are ignored.
- FSM states:
  - IDLE:
    - armed & ne1s=0 & nwes=0 -> WR_CAP.
    - Otherwise armed & ne1s=0 & noes=0 -> RD_REQ; address captured this cycle.
    - nwes wins over noes when both are low.
  - WR_CAP: on nwes rising or ne1s rising -> WR_REQ, with mem_req=1 on the next cycle. The write commits at strobe end, so latency is SYNC_STAGES+1 clk from the pin rising edge to mem_req.
  - WR_REQ: hold mem_req, mem_we=1 and the payload stable until mem_ack; mem_req drops the cycle after ack -> IDLE.
  - RD_REQ: mem_req=1, mem_we=0, mem_wmask=2'b11, until mem_ack -> RD_WAIT.
  - RD_WAIT: on mem_rvalid, load fsmc_d_out <= mem_rdata.
    - If ne1s=0 & noes=0 still -> RD_HOLD.
    - Otherwise the data is discarded -> IDLE.
    - mem_rvalid is always consumed, even if the host aborted.
  - RD_HOLD: stay until ne1s=1 or noes=1 -> IDLE.
- fsmc_d_oe = (state==RD_HOLD) & ~fsmc_ne1 & ~fsmc_noe, using the raw pins combinationally. Drive therefore releases immediately on the host's NOE rise, with no contention during turnaround.
- overrun: sets when a new ne1s falling edge occurs in any state other than IDLE or RD_HOLD. It clears only on rst. The colliding cycle is dropped.
- mem_ack arriving outside WR_REQ/RD_REQ is ignored. mem_rvalid arriving outside RD_WAIT is ignored.
- A host read whose NOE is shorter than the request latency yields undriven data. The NWAIT feature exists to prevent this.

Optional Feature:
- Macro FSMC_NWAIT_EN.
- Defined:
  - Adds output port fsmc_nwait (1 bit, active low).
  - fsmc_nwait = 0 while state is in {WR_CAP, WR_REQ, RD_REQ, RD_WAIT} and ne1s=0; 1 otherwise. Reset value is 1.
  - The host stalls until read data is driven.
- Undefined: the port is absent and the host relies on programmed FSMC timing.

Decomposition:
- Package fsmc_bridge_pkg holds:
  - The FSM state encoding: IDLE, WR_CAP, WR_REQ, RD_REQ, RD_WAIT, RD_HOLD.
  - Default widths: FSMC_AW=16, MEM_AW=22.
- One sub-module, fsmc_sync: a SYNC_STAGES-deep bus synchroniser instanced once over {ne1, nwe, noe, nbl1, nbl0, a, d_in}.

Test Plan:
- Write 0xAAAA to 0x0000 (NE1/NWE low 5 us, nbl=00), then 0x5555 to 0x0111 -> exactly one mem_req per write, with mem_we=1, addr 0x000000/0x000111, wdata AAAA/5555, wmask 11, each after the strobe rises.
- Read 0x0000 after the writes, controller returns rdata=0xAAAA 4 clk after ack -> fsmc_d_out=AAAA, fsmc_d_oe=1 while NOE/NE1 low, fsmc_d_oe=0 in the same delta as NOE rises.
- Byte write with nbl1=1, nbl0=0, data 0x12FF -> mem_wmask=01, wdata 0x12FF.
- Hold mem_ack low 20 clk during a write -> mem_req and all payload fields stable for 20 clk; mem_req drops the cycle after ack.
- Assert rst mid-RD_WAIT while NE1/NOE are still low -> outputs 0 and fsmc_d_oe=0 next clk; no new request until NE1 has gone high and a fresh cycle starts.
- Start a second NE1 cycle while WR_REQ is pending (ack stalled) -> overrun=1 and sticky, the second cycle issues no request. With FSMC_NWAIT_EN defined, also check fsmc_nwait=0 for the whole pending period.
